// File: rtl/parc_test_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : parc_test_mem_responder
//  Description : Slave end of the val/rdy memory request/response protocol.
//                Performs word/half/byte reads and writes on an internal
//                byte-lane array and returns responses through a fixed-depth
//                latency pipe. A host init port preloads whole words.
//  Revision    : 1.0  initial release
// ============================================================================
module parc_test_mem_responder #(
    parameter int p_mem_sz    = 65536,
    parameter int p_latency   = 1,
    parameter int p_stall_per = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [66:0] memreq_msg,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    output logic [34:0] memresp_msg,
    output logic        memresp_val,
    input  logic        init_en,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data,
    output logic        err_oob
);

    localparam int          c_aw      = $clog2(p_mem_sz);
    localparam int          c_iw      = (c_aw > 2) ? c_aw - 2 : 1;
    localparam int          c_words   = p_mem_sz / 4;
    localparam logic [32:0] c_mem_lim = 33'(p_mem_sz);

    // Word-organised storage; lanes are little-endian within a word
    logic [31:0] r_mem [0:c_words-1];

    logic [34:0] r_pipe_msg [p_latency];
    logic        r_pipe_val [p_latency];
    logic        r_err_oob;

    logic            w_throttle;
    logic            w_fire;
    logic            w_req_type;
    logic [31:0]     w_req_addr;
    logic [1:0]      w_req_len;
    logic [31:0]     w_req_data;
    logic            w_req_oob;
    logic [c_iw-1:0] w_req_idx;
    logic            w_init_oob;
    logic [c_iw-1:0] w_init_idx;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_rd_data;
    logic [3:0]      w_wr_be;
    logic [31:0]     w_wr_data;
    logic [34:0]     w_resp_msg;

    assign w_req_type = memreq_msg[66];
    assign w_req_addr = memreq_msg[65:34];
    assign w_req_len  = memreq_msg[33:32];
    assign w_req_data = memreq_msg[31:0];

    // Range checks use the full 32-bit address so high addresses never alias
    assign w_req_oob  = {1'b0, w_req_addr} >= c_mem_lim;
    assign w_init_oob = {1'b0, init_addr}  >= c_mem_lim;
    assign w_req_idx  = c_iw'(w_req_addr >> 2);
    assign w_init_idx = c_iw'(init_addr >> 2);

    assign memreq_rdy = !reset && !init_en && !w_throttle;
    assign w_fire     = memreq_val && memreq_rdy;

    generate
        if (p_stall_per != 0) begin : g_throttle
            localparam int            c_sw        = (p_stall_per > 1) ? $clog2(p_stall_per) : 1;
            localparam logic [c_sw-1:0] c_stall_last = c_sw'(p_stall_per - 1);
            logic [c_sw-1:0] r_stall_cnt;

            // Free-running phase counter; the last phase of each period blocks requests
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stall_cnt <= '0;
                end else if (r_stall_cnt == c_stall_last) begin
                    r_stall_cnt <= '0;
                end else begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end

            assign w_throttle = (r_stall_cnt == c_stall_last);
        end else begin : g_no_throttle
            assign w_throttle = 1'b0;
        end
    endgenerate

    assign w_rd_word = r_mem[w_req_idx];

    // Lane selection for reads (zero-extended, LSB aligned) and write byte enables
    always_comb begin
        w_rd_data = w_rd_word;
        w_wr_be   = 4'b1111;
        w_wr_data = w_req_data;
        case (w_req_len)
            2'd1: begin
                w_wr_data = {4{w_req_data[7:0]}};
                case (w_req_addr[1:0])
                    2'd0:    begin w_rd_data = {24'b0, w_rd_word[7:0]};   w_wr_be = 4'b0001; end
                    2'd1:    begin w_rd_data = {24'b0, w_rd_word[15:8]};  w_wr_be = 4'b0010; end
                    2'd2:    begin w_rd_data = {24'b0, w_rd_word[23:16]}; w_wr_be = 4'b0100; end
                    default: begin w_rd_data = {24'b0, w_rd_word[31:24]}; w_wr_be = 4'b1000; end
                endcase
            end
            2'd2: begin
                w_wr_data = {2{w_req_data[15:0]}};
                if (w_req_addr[1]) begin
                    w_rd_data = {16'b0, w_rd_word[31:16]};
                    w_wr_be   = 4'b1100;
                end else begin
                    w_rd_data = {16'b0, w_rd_word[15:0]};
                    w_wr_be   = 4'b0011;
                end
            end
            default: begin
                w_rd_data = w_rd_word;
                w_wr_be   = 4'b1111;
                w_wr_data = w_req_data;
            end
        endcase
        if (w_req_oob) begin
            w_rd_data = 32'b0;
        end
    end

    assign w_resp_msg = {w_req_type, w_req_len, w_req_type ? 32'b0 : w_rd_data};

    // Array updates: init words and in-range request writes (never in the same cycle)
    always_ff @(posedge clk) begin
        if (init_en && !w_init_oob) begin
            r_mem[w_init_idx] <= init_data;
        end else if (w_fire && w_req_type && !w_req_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[w_req_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Latency pipe valids and the sticky out-of-range flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_latency; i++) begin
                r_pipe_val[i] <= 1'b0;
            end
            r_err_oob <= 1'b0;
        end else begin
            r_pipe_val[0] <= w_fire;
            for (int i = 1; i < p_latency; i++) begin
                r_pipe_val[i] <= r_pipe_val[i-1];
            end
            if (w_fire && w_req_oob) begin
                r_err_oob <= 1'b1;
            end
        end
    end

    // Latency pipe payload; read data is captured at fire time
    always_ff @(posedge clk) begin
        r_pipe_msg[0] <= w_resp_msg;
        for (int i = 1; i < p_latency; i++) begin
            r_pipe_msg[i] <= r_pipe_msg[i-1];
        end
    end

    assign memresp_val = r_pipe_val[p_latency-1];
    assign memresp_msg = r_pipe_msg[p_latency-1];
    assign err_oob     = r_err_oob;

endmodule
`default_nettype wire

// File: tb/tb_parc_test_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parc_test_mem_responder
//  Description : Randomised scoreboard bench for parc_test_mem_responder with
//                a byte-array reference model of the memory and protocol.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parc_test_mem_responder;

    localparam int MEMSZ = 65536;
    localparam int LAT   = 3;
    localparam int STALL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [66:0] memreq_msg;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [34:0] memresp_msg;
    logic        memresp_val;
    logic        init_en;
    logic [31:0] init_addr;
    logic [31:0] init_data;
    logic        err_oob;

    parc_test_mem_responder #(
        .p_mem_sz    (MEMSZ),
        .p_latency   (LAT),
        .p_stall_per (STALL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .init_en     (init_en),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .err_oob     (err_oob)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [34:0] msg;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] mmem [0:MEMSZ-1];
    int         cyc    = 0;
    int         mcnt   = 0;
    bit         m_err  = 1'b0;
    bit         last_fire = 1'b0;
    bit         mon_en = 1'b0;
    int         tests  = 0;
    int         fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    function automatic bit model_rdy();
        return !reset && !init_en && (mcnt != STALL - 1);
    endfunction

    // Reference behaviour of one accepted request, expressed on a byte array
    function automatic void model_req(input logic [66:0] m, input int due);
        bit          typ;
        logic [31:0] addr, data, rd, base;
        logic [1:0]  len;
        int          nb;
        exp_t        e;
        typ  = m[66];
        addr = m[65:34];
        len  = m[33:32];
        data = m[31:0];
        nb   = (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : 4;
        base = (len == 2'd1) ? addr : (len == 2'd2) ? (addr & ~32'd1) : (addr & ~32'd3);
        rd   = 32'h0;
        if ({1'b0, addr} >= 33'(MEMSZ)) begin
            m_err = 1'b1;
        end else begin
            for (int i = 0; i < nb; i++) begin
                if (typ) mmem[base + i] = data[8*i +: 8];
                else     rd = rd | (32'(mmem[base + i]) << (8 * i));
            end
        end
        e.due = due;
        e.msg = {typ, len, typ ? 32'h0 : rd};
        q.push_back(e);
    endfunction

    // Advance one clock edge and apply the model's view of what happened at it
    task automatic tick();
        bit f;
        @(posedge clk);
        cyc++;
        f = memreq_val && model_rdy();
        if (reset) begin
            q.delete();
            mcnt  = 0;
            m_err = 1'b0;
        end else begin
            if (init_en && ({1'b0, init_addr} < 33'(MEMSZ))) begin
                for (int i = 0; i < 4; i++) mmem[{init_addr[31:2], 2'b00} + i] = init_data[8*i +: 8];
            end
            if (f) model_req(memreq_msg, cyc + LAT - 1);
            mcnt = (mcnt + 1) % STALL;
        end
        last_fire = f;
        #1;
    endtask

    task automatic send(input bit typ, input logic [1:0] len, input logic [31:0] addr, input logic [31:0] data);
        memreq_val = 1'b1;
        memreq_msg = {typ, addr, len, data};
        for (int k = 0; k < 8; k++) begin
            tick();
            if (last_fire) break;
        end
        if (!last_fire) begin
            tests++;
            fails++;
            $display("FAIL req_accept timeout addr=%0h", addr);
        end
    endtask

    task automatic idle(input int n);
        memreq_val = 1'b0;
        repeat (n) tick();
    endtask

    task automatic init_wr(input logic [31:0] a, input logic [31:0] d);
        init_en   = 1'b1;
        init_addr = a;
        init_data = d;
        tick();
        init_en = 1'b0;
    endtask

    task automatic rand_traffic(input int n, input bit allow_oob);
        logic [31:0] a;
        int          r;
        for (int t = 0; t < n; t++) begin
            r = $urandom % 10;
            if (r == 0) begin
                idle(1);
            end else if (r == 1) begin
                init_wr(($urandom % 1024) & ~32'd3, $urandom);
            end else begin
                if (allow_oob && ($urandom % 16 == 0)) a = 32'h10000 + ($urandom % 64);
                else                                   a = $urandom % 1024;
                send(1'($urandom % 2), 2'($urandom % 4), a, $urandom);
            end
        end
        memreq_val = 1'b0;
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            check("rdy", 64'(memreq_rdy), 64'(model_rdy()));
            check("err_oob", 64'(err_oob), 64'(m_err));
            if (memresp_val === 1'b1) begin
                if (q.size() == 0) begin
                    check("resp_val_unexpected", 64'(memresp_val), 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("resp_msg", 64'(memresp_msg), 64'(mon_e.msg));
                    check("resp_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                check("resp_val_missing", 64'(memresp_val), 64'd1);
                mon_e = q.pop_front();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        memreq_val = 1'b0;
        memreq_msg = '0;
        init_en    = 1'b0;
        init_addr  = '0;
        init_data  = '0;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Preload the working region, then the known word and a dropped out-of-range init
        for (int w = 0; w < 256; w++) init_wr(32'(w * 4), $urandom);
        init_wr(32'h100, 32'hDEADBEEF);
        init_wr(32'h10000, 32'h12345678);
        idle(2);

        // Lane checks around the known word, then write-then-read
        send(1'b0, 2'd0, 32'h100, 32'h0);
        send(1'b0, 2'd1, 32'h103, 32'h0);
        send(1'b0, 2'd2, 32'h102, 32'h0);
        send(1'b1, 2'd1, 32'h101, 32'h000000AA);
        send(1'b0, 2'd0, 32'h100, 32'h0);
        send(1'b1, 2'd0, 32'h200, 32'hCAFEF00D);
        send(1'b0, 2'd0, 32'h200, 32'h0);
        send(1'b1, 2'd2, 32'h206, 32'h00005A5A);
        send(1'b0, 2'd3, 32'h205, 32'h0);
        idle(LAT + 2);

        // Back-to-back reads with val held high across throttle cycles
        for (int i = 0; i < 8; i++) send(1'b0, 2'd0, 32'(i * 4), 32'h0);
        idle(LAT + 2);

        rand_traffic(300, 1'b0);
        idle(LAT + 2);

        // Out-of-range read and write
        send(1'b0, 2'd0, 32'h10000, 32'h0);
        send(1'b1, 2'd0, 32'hFFFFFFFC, 32'h11111111);
        idle(4);

        // Reset with two reads in flight; nothing may come out afterwards
        send(1'b1, 2'd0, 32'h300, 32'h0BADC0DE);
        send(1'b0, 2'd0, 32'h100, 32'h0);
        send(1'b0, 2'd0, 32'h300, 32'h0);
        memreq_val = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        idle(LAT + 2);

        // Memory survives reset
        for (int i = 0; i < 16; i++) send(1'b0, 2'd0, 32'h300 + 32'(i * 4), 32'h0);
        send(1'b0, 2'd0, 32'h100, 32'h0);
        idle(LAT + 2);

        rand_traffic(400, 1'b1);
        idle(LAT + 3);

        check("drain_queue_empty", 64'(q.size()), 64'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
